// File: rtl/unary_binary_dot_mac_if.sv
// unary_binary_dot_mac_if: operand/result handshake bundle for the unary/binary dot-product MAC
interface unary_binary_dot_mac_if #(
    parameter int SIZE  = 4,
    parameter int LANES = 4,
    parameter int OUT_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*SIZE-1:0] a;
    logic [LANES*SIZE-1:0] b;
    logic [SIZE-1:0]       c;
    logic                  acc_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W-1:0]      out;

    modport master (
        output in_valid, a, b, c, acc_en, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, c, acc_en, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/unary_binary_dot_mac.sv
// unary_binary_dot_mac: multi-lane dot-product MAC, a/c streamed as thermometer pulses, b applied as binary masks
module unary_binary_dot_mac #(
    parameter int SIZE  = 4,
    parameter int LANES = 4,
    parameter int OUT_W = 16
) (
    input logic                   clk,
    input logic                   reset_n,
    unary_binary_dot_mac_if.slave bus
);
    localparam int ADD_W = SIZE + $clog2(LANES + 1) + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [LANES*SIZE-1:0] r_a;
    logic [LANES*SIZE-1:0] r_b;
    logic [SIZE-1:0]       r_c;
    logic [SIZE-1:0]       r_len;
    logic [SIZE-1:0]       r_cnt;
    logic [OUT_W-1:0]      r_acc;
    logic [OUT_W-1:0]      r_out;
    logic [SIZE-1:0]       w_len;
    logic [ADD_W-1:0]      w_addend;
    logic [OUT_W-1:0]      w_acc_next;
    logic [OUT_W-1:0]      w_seed;

    // Run length is the longest thermometer among all a lanes and c
    always_comb begin
        w_len = bus.c;
        for (int k = 0; k < LANES; k++)
            w_len = (bus.a[k*SIZE +: SIZE] > w_len) ? bus.a[k*SIZE +: SIZE] : w_len;
    end

    always_comb begin
        w_addend = ADD_W'(r_cnt < r_c);
        for (int k = 0; k < LANES; k++)
            w_addend = w_addend + ((r_cnt < r_a[k*SIZE +: SIZE]) ? ADD_W'(r_b[k*SIZE +: SIZE]) : '0);
    end

    assign w_acc_next    = r_acc + OUT_W'(w_addend);
    assign w_seed        = bus.acc_en ? r_out : '0;
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out       = r_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a   <= bus.a;
                    r_b   <= bus.b;
                    r_c   <= bus.c;
                    r_len <= w_len;
                    r_cnt <= '0;
                    r_acc <= w_seed;
                    if (w_len == '0) begin
                        r_out   <= w_seed;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + SIZE'(1);
                    if (r_cnt == r_len - SIZE'(1)) begin
                        r_out   <= w_acc_next;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unary_binary_dot_mac.sv
// tb_unary_binary_dot_mac: vector table plus backpressure and mid-run reset sequences, scoreboard-checked
module tb_unary_binary_dot_mac;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  c;
        logic        en;
        logic [15:0] e;
        int          len;
    } vec_t;

    logic clk = 0;
    logic reset_n = 0;
    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    vec_t vecs[9];

    unary_binary_dot_mac_if #(.SIZE(4), .LANES(4), .OUT_W(16)) bus ();

    unary_binary_dot_mac #(.SIZE(4), .LANES(4), .OUT_W(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 1);
        bus.a = v.a;
        bus.b = v.b;
        bus.c = v.c;
        bus.acc_en = v.en;
        bus.in_valid = 1;
        @(posedge clk);
        exp_q.push_back(v.e);
        #1 bus.in_valid = 0;
    endtask

    task automatic wait_result(input vec_t v, input string tag);
        int n = 0;
        logic busy_ok = 1;
        logic [15:0] e;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) busy_ok = 0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_latency"}, n, v.len);
        chk({tag, "_in_ready_low"}, 32'(busy_ok), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, "_out"}, 32'(bus.out), 32'(e));
    endtask

    task automatic release_out();
        bus.out_ready = 1;
        @(posedge clk);
        #1 bus.out_ready = 0;
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.out_valid), 0);
        chk("idle_in_ready", 32'(bus.in_ready), 1);
    endtask

    initial begin
        vec_t bp, after, mx, post;
        vecs[0] = '{16'h0003, 16'h7775, 4'd2, 1'b0, 16'd17, 3};
        vecs[1] = '{16'h0000, 16'h0000, 4'd0, 1'b0, 16'd0, 0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 4'd15, 1'b0, 16'd915, 15};
        vecs[3] = '{16'h0003, 16'h7775, 4'd2, 1'b0, 16'd17, 3};
        vecs[4] = '{16'h0022, 16'h0043, 4'd1, 1'b1, 16'd32, 2};
        vecs[5] = '{16'h4321, 16'h1234, 4'd5, 1'b0, 16'd25, 5};
        vecs[6] = '{16'h0000, 16'h0000, 4'd0, 1'b1, 16'd25, 0};
        vecs[7] = '{16'h9000, 16'hF000, 4'd0, 1'b1, 16'd160, 9};
        vecs[8] = '{16'h0000, 16'h0000, 4'd7, 1'b1, 16'd167, 7};
        bp    = '{16'h0002, 16'h0003, 4'd0, 1'b0, 16'd6, 2};
        after = '{16'h0001, 16'h0001, 4'd0, 1'b1, 16'd7, 1};
        mx    = '{16'hFFFF, 16'hFFFF, 4'd15, 1'b0, 16'd915, 15};
        post  = '{16'h0001, 16'h0001, 4'd0, 1'b1, 16'd1, 1};

        bus.in_valid = 0;
        bus.out_ready = 0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        bus.acc_en = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i]);
            wait_result(vecs[i], $sformatf("vec%0d", i));
            release_out();
        end

        // Backpressure: result held while new operands are offered and refused
        drive(bp);
        wait_result(bp, "bp");
        for (int i = 0; i < 5; i++) begin
            bus.a = 16'hFFFF;
            bus.b = 16'hFFFF;
            bus.c = 4'hF;
            bus.acc_en = 1;
            bus.in_valid = 1;
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_out", 32'(bus.out), 6);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 0;
        release_out();
        chk("bp_out_kept_idle", 32'(bus.out), 6);
        drive(after);
        wait_result(after, "bp_after");
        release_out();

        // Asynchronous reset in the middle of a max-length run
        drive(mx);
        repeat (5) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_out", 32'(bus.out), 0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1;
        drive(post);
        wait_result(post, "post_rst");
        release_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
